// File: rtl/pc_next_unit_if.sv
// Request/response bundle for pc_next_unit: redirect requests in, fetch PC and status out.
// Request levels are sampled on every rising clk edge; no valid/ready handshake, stall is the only hold.
interface pc_next_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             stall;
    logic             inst_len16;
    logic             branch_taken;
    logic [XLEN-1:0]  branch_target;
    logic             jalr;
    logic [XLEN-1:0]  jalr_target;
    logic             trap_req;
    logic [XLEN-1:0]  pc;
    logic [1:0]       pc_sel_src;
    logic             redirect_pending;
    logic             misalign_exc;
    logic [CNT_W-1:0] redirect_cnt;

    modport master (
        output stall, inst_len16, branch_taken, branch_target, jalr, jalr_target, trap_req,
        input  pc, pc_sel_src, redirect_pending, misalign_exc, redirect_cnt
    );

    modport slave (
        input  stall, inst_len16, branch_taken, branch_target, jalr, jalr_target, trap_req,
        output pc, pc_sel_src, redirect_pending, misalign_exc, redirect_cnt
    );
endinterface

// File: rtl/pc_next_unit.sv
// Registered PC update unit: arbitrates seq/branch/JALR/trap, holds one pending redirect across stalls.
// Misaligned targets are converted to a trap to TRAP_VECTOR with a one-cycle misalign_exc pulse.
module pc_next_unit #(
    parameter int              XLEN         = 32,
    parameter int              IALIGN       = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(4),
    parameter int              CNT_W        = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_next_unit_if.slave  bus
);
    localparam logic [1:0] SEL_SEQ  = 2'b00;
    localparam logic [1:0] SEL_BR   = 2'b01;
    localparam logic [1:0] SEL_JALR = 2'b10;
    localparam logic [1:0] SEL_TRAP = 2'b11;

    if (IALIGN != 16 && IALIGN != 32) begin : g_bad_ialign
        $error("pc_next_unit: IALIGN must be 16 or 32");
    end
    if (TRAP_VECTOR[0] || (IALIGN == 32 && TRAP_VECTOR[1])) begin : g_bad_trap_vec
        $error("pc_next_unit: TRAP_VECTOR is not aligned to IALIGN");
    end

    logic [XLEN-1:0]  r_pc;
    logic             r_pend_valid;
    logic [1:0]       r_pend_sel;
    logic [XLEN-1:0]  r_pend_tgt;
    logic             r_pend_mis;
    logic             r_mis_exc;
    logic [CNT_W-1:0] r_cnt;

    logic [XLEN-1:0]  w_seq;
    logic [XLEN-1:0]  w_jalr_tgt;
    logic [1:0]       w_live_sel;
    logic [1:0]       w_live_prio;
    logic [XLEN-1:0]  w_live_tgt;
    logic             w_live_mis;
    logic [1:0]       w_eff_sel;
    logic [XLEN-1:0]  w_eff_tgt;
    logic             w_eff_mis;
    logic             w_capture;

    assign w_seq      = r_pc + ((IALIGN == 16 && bus.inst_len16) ? XLEN'(2) : XLEN'(4));
    assign w_jalr_tgt = {bus.jalr_target[XLEN-1:1], 1'b0};

    // Live request arbitration; a misaligned target degrades into a trap redirect.
    always_comb begin
        w_live_sel  = SEL_SEQ;
        w_live_prio = 2'd0;
        w_live_tgt  = w_seq;
        w_live_mis  = 1'b0;
        if (bus.trap_req) begin
            w_live_sel  = SEL_TRAP;
            w_live_prio = 2'd3;
            w_live_tgt  = TRAP_VECTOR;
        end else if (bus.jalr) begin
            w_live_prio = 2'd2;
            if (IALIGN == 32 && w_jalr_tgt[1]) begin
                w_live_sel = SEL_TRAP;
                w_live_tgt = TRAP_VECTOR;
                w_live_mis = 1'b1;
            end else begin
                w_live_sel = SEL_JALR;
                w_live_tgt = w_jalr_tgt;
            end
        end else if (bus.branch_taken) begin
            w_live_prio = 2'd1;
            if (bus.branch_target[0] || (IALIGN == 32 && bus.branch_target[1])) begin
                w_live_sel = SEL_TRAP;
                w_live_tgt = TRAP_VECTOR;
                w_live_mis = 1'b1;
            end else begin
                w_live_sel = SEL_BR;
                w_live_tgt = bus.branch_target;
            end
        end
    end

    always_comb begin
        w_eff_sel = w_live_sel;
        w_eff_tgt = w_live_tgt;
        w_eff_mis = w_live_mis;
        if (r_pend_valid) begin
            w_eff_sel = r_pend_sel;
            w_eff_tgt = r_pend_tgt;
            w_eff_mis = r_pend_mis;
        end
    end

    // Stored priority is the stored selection code, so a misaligned capture ranks as a trap.
    assign w_capture = (w_live_prio != 2'd0) && (!r_pend_valid || (w_live_prio >= r_pend_sel));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_VECTOR;
            r_pend_valid <= 1'b0;
            r_pend_sel   <= SEL_SEQ;
            r_pend_tgt   <= '0;
            r_pend_mis   <= 1'b0;
            r_mis_exc    <= 1'b0;
            r_cnt        <= '0;
        end else if (bus.stall) begin
            r_mis_exc <= 1'b0;
            if (w_capture) begin
                r_pend_valid <= 1'b1;
                r_pend_sel   <= w_live_sel;
                r_pend_tgt   <= w_live_tgt;
                r_pend_mis   <= w_live_mis;
            end
        end else begin
            r_pc         <= w_eff_tgt;
            r_pend_valid <= 1'b0;
            r_mis_exc    <= w_eff_mis;
            if (w_eff_sel != SEL_SEQ && !(&r_cnt)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.pc               = r_pc;
    assign bus.pc_sel_src       = bus.stall ? SEL_SEQ : w_eff_sel;
    assign bus.redirect_pending = r_pend_valid;
    assign bus.misalign_exc     = r_mis_exc;
    assign bus.redirect_cnt     = r_cnt;
endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: three instances (IALIGN=32, IALIGN=16, CNT_W=2) share one stimulus stream.
// Each phase checks the instance whose configuration the phase targets against hand-computed values.
module tb_pc_next_unit;
    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        inst_len16;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jalr;
    logic [31:0] jalr_target;
    logic        trap_req;

    int n_vec;
    int n_miscmp;

    pc_next_unit_if #(.XLEN(32), .CNT_W(16)) if32 ();
    pc_next_unit_if #(.XLEN(32), .CNT_W(16)) if16 ();
    pc_next_unit_if #(.XLEN(32), .CNT_W(2))  ifc  ();

    pc_next_unit #(.XLEN(32), .IALIGN(32), .CNT_W(16)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
    pc_next_unit #(.XLEN(32), .IALIGN(16), .CNT_W(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
    pc_next_unit #(.XLEN(32), .IALIGN(32), .CNT_W(2))  u_dutc  (.clk(clk), .rst_n(rst_n), .bus(ifc));

    assign if32.stall = stall;         assign if16.stall = stall;         assign ifc.stall = stall;
    assign if32.inst_len16 = inst_len16;       assign if16.inst_len16 = inst_len16;
    assign ifc.inst_len16 = inst_len16;
    assign if32.branch_taken = branch_taken;   assign if16.branch_taken = branch_taken;
    assign ifc.branch_taken = branch_taken;
    assign if32.branch_target = branch_target; assign if16.branch_target = branch_target;
    assign ifc.branch_target = branch_target;
    assign if32.jalr = jalr;           assign if16.jalr = jalr;           assign ifc.jalr = jalr;
    assign if32.jalr_target = jalr_target;     assign if16.jalr_target = jalr_target;
    assign ifc.jalr_target = jalr_target;
    assign if32.trap_req = trap_req;   assign if16.trap_req = trap_req;   assign ifc.trap_req = trap_req;

    // clock/reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        stall         = 1'b0;
        inst_len16    = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jalr          = 1'b0;
        jalr_target   = 32'h0;
        trap_req      = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_cnt_sat [5];

    initial begin
        n_vec    = 0;
        n_miscmp = 0;
        exp_cnt_sat = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3};
        rst_n = 1'b0;
        drive_idle();

        // Reset values, then free-running sequential fetch
        #12;
        check("rst_pc",      if32.pc, 32'h0);
        check("rst_pending", 32'(if32.redirect_pending), 32'h0);
        check("rst_misalign", 32'(if32.misalign_exc), 32'h0);
        check("rst_cnt",     32'(if32.redirect_cnt), 32'h0);
        rst_n = 1'b1;
        check("seq_sel", 32'(if32.pc_sel_src), 32'h0);
        cycle();
        check("seq_pc1", if32.pc, 32'h4);
        cycle();
        check("seq_pc2", if32.pc, 32'h8);
        cycle();
        check("seq_pc3", if32.pc, 32'hC);
        check("seq_cnt", 32'(if32.redirect_cnt), 32'h0);

        // All three requests at once: trap wins
        trap_req = 1'b1; jalr = 1'b1; jalr_target = 32'h201;
        branch_taken = 1'b1; branch_target = 32'h300;
        #1;
        check("prio_sel", 32'(if32.pc_sel_src), 32'h3);
        cycle();
        check("prio_pc",  if32.pc, 32'h4);
        check("prio_cnt", 32'(if32.redirect_cnt), 32'h1);
        drive_idle();

        // 16-bit alignment build: compressed +2, full-length +4
        branch_taken = 1'b1; branch_target = 32'h100;
        #1;
        check("br_sel", 32'(if16.pc_sel_src), 32'h1);
        cycle();
        check("br16_pc", if16.pc, 32'h100);
        drive_idle();
        inst_len16 = 1'b1;
        cycle();
        check("c16_pc", if16.pc, 32'h102);
        check("c32_pc", if32.pc, 32'h104);
        inst_len16 = 1'b0;
        cycle();
        check("i16_pc", if16.pc, 32'h106);

        // Stall with pending capture: branch, then higher-priority jalr overwrites
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h400;
        #1;
        check("stall_sel", 32'(if32.pc_sel_src), 32'h0);
        cycle();
        check("stall_pend1", 32'(if32.redirect_pending), 32'h1);
        check("stall_hold1", if32.pc, 32'h108);
        branch_taken = 1'b0; jalr = 1'b1; jalr_target = 32'h501;
        cycle();
        jalr = 1'b0;
        cycle();
        check("stall_pend3", 32'(if32.redirect_pending), 32'h1);
        check("stall_hold3", if32.pc, 32'h108);
        // Release with a live branch that the pending jalr supersedes
        stall = 1'b0; branch_taken = 1'b1; branch_target = 32'h700;
        #1;
        check("rel_sel", 32'(if32.pc_sel_src), 32'h2);
        cycle();
        check("rel_pc",   if32.pc, 32'h500);
        check("rel_pend", 32'(if32.redirect_pending), 32'h0);
        check("rel_cnt",  32'(if32.redirect_cnt), 32'h3);
        drive_idle();

        // Misaligned JALR: trap on IALIGN=32, legal on IALIGN=16
        jalr = 1'b1; jalr_target = 32'h1002;
        #1;
        check("mis_sel", 32'(if32.pc_sel_src), 32'h3);
        check("mis16_sel", 32'(if16.pc_sel_src), 32'h2);
        cycle();
        check("mis_pc",   if32.pc, 32'h4);
        check("mis_exc",  32'(if32.misalign_exc), 32'h1);
        check("jalr16_pc", if16.pc, 32'h1002);
        check("jalr16_exc", 32'(if16.misalign_exc), 32'h0);
        drive_idle();
        cycle();
        check("mis_exc_drop", 32'(if32.misalign_exc), 32'h0);
        check("mis_seq_pc",   if32.pc, 32'h8);
        branch_taken = 1'b1; branch_target = 32'h2001;
        cycle();
        check("br16_odd_pc",  if16.pc, 32'h4);
        check("br16_odd_exc", 32'(if16.misalign_exc), 32'h1);
        drive_idle();

        // Asynchronous reset while a redirect is pending
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h800;
        cycle();
        check("arst_pend_pre", 32'(if32.redirect_pending), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pc",   if32.pc, 32'h0);
        check("arst_pend", 32'(if32.redirect_pending), 32'h0);
        #1;
        rst_n = 1'b1;
        stall = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;

        // Saturating counter with CNT_W=2
        for (int i = 0; i < 5; i++) begin
            cycle();
            check($sformatf("sat_cnt%0d", i), 32'(ifc.redirect_cnt), exp_cnt_sat[i]);
        end
        check("sat_pc",     ifc.pc, 32'h40);
        check("nosat_cnt",  32'(if32.redirect_cnt), 32'h5);
        drive_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Registered program-counter update unit; successor to the combinational next-PC select generator.
- Owns the PC register and arbitrates sequential / branch-JAL / JALR / trap redirects.
- Holds a one-deep pending redirect across stalls; checks target alignment for RV32I (IALIGN=32) or RV16I/compressed (IALIGN=16) builds.
- Keeps a saturating redirect counter; drives the fetch address and the legacy 2-bit pc_sel_src code.

Parameters:
- XLEN, 32, PC and target width.
- IALIGN, 32, instruction alignment in bits; 16 or 32 only.
- RESET_VECTOR, 0, PC value after reset.
- TRAP_VECTOR, 4, PC loaded on trap or misaligned target; must itself be aligned.
- CNT_W, 16, redirect counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC this cycle.
- inst_len16  in  1  current instruction is 16-bit; ignored when IALIGN=32.
- branch_taken  in  1  taken conditional branch or JAL.
- branch_target  in  XLEN  target for branch/JAL.
- jalr  in  1  JALR executing.
- jalr_target  in  XLEN  raw rs1+imm.
- trap_req  in  1  ECALL/EBREAK/SYSTEM trap.
- pc  out  XLEN  current fetch PC, registered.
- pc_sel_src  out  2  selection applied this cycle: 00 seq, 01 branch, 10 jalr, 11 trap.
- redirect_pending  out  1  a captured redirect awaits release, registered.
- misalign_exc  out  1  one-cycle pulse, registered; the last PC update was a misalign trap.
- redirect_cnt  out  CNT_W  saturating count of applied non-sequential updates.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - pc=RESET_VECTOR
  - redirect_pending=0
  - misalign_exc=0
  - redirect_cnt=0
  - pending type/target cleared
- Reset assertion mid-operation discards any pending redirect immediately.
- Live request priority: trap_req > jalr > branch_taken > sequential; lower requests are ignored.
- JALR target is {jalr_target[XLEN-1:1],1'b0}. Branch target is used as-is.
- Alignment: a chosen branch or JALR target is misaligned if:
  - IALIGN=32: target[1]=1, or target[0]=1 for a branch.
  - IALIGN=16: target[0]=1 (branch only; JALR bit0 is already cleared).
  - A misaligned target is replaced by TRAP_VECTOR, classified as trap (11), and sets misalign_exc=1 on the update edge.
- Sequential increment:
  - IALIGN=32: pc+4.
  - IALIGN=16: pc+2 when inst_len16=1, else pc+4.
  - Wraps modulo 2^XLEN.
- Effective selection = pending entry if redirect_pending=1, else the live request.
- Non-stall cycle: pc <= effective next value. A pending entry is consumed, and live requests that cycle are ignored; the consumed redirect already superseded them. redirect_pending <= 0.
- Stall cycle:
  - pc holds.
  - If a live non-sequential request exists, capture it into the pending entry when the entry is empty, or when the live priority is greater than or equal to the stored priority (newest wins on a tie). Set redirect_pending=1.
  - Otherwise the pending entry holds.
  - Alignment is checked at capture; a misaligned capture is stored as a trap.
- pc_sel_src is combinational:
  - Shows the effective selection while stall=0.
  - Shows 00 while stall=1; pc is not changing.
- misalign_exc is high for exactly one cycle after the update that used a misaligned target. It is 0 otherwise, including during stalls.
- redirect_cnt increments by 1 on each non-stall update with pc_sel_src≠00, and holds at all-ones.
- Legal IALIGN values are 16 and 32; any other value is an elaboration error.

Test Plan:
- Reset release with no requests, IALIGN=32, 3 cycles: pc 0x0→0x4→0x8→0xC; pc_sel_src=00; redirect_cnt=0.
- IALIGN=16, pc=0x100, inst_len16=1, then 0: pc 0x102 then 0x106.
- Same cycle trap_req=1, jalr=1 (0x201), branch_taken=1 (0x300): pc_sel_src=11, pc=TRAP_VECTOR=0x4, redirect_cnt=1.
- stall=1 for 3 cycles:
  - cycle 1: branch_taken to 0x400.
  - cycle 2: jalr to 0x501.
  - cycle 3: nothing.
  - Then stall=0 → redirect_pending=1 through the stall; pc=0x500, pc_sel_src=10, redirect_pending=0 next cycle.
- IALIGN=32, jalr_target=0x1002: pc=0x4, pc_sel_src=11, misalign_exc high exactly one cycle. Same case with IALIGN=16: pc=0x1002, no exception.
- CNT_W=2, 5 consecutive taken branches: redirect_cnt 1,2,3,3,3. Assert rst_n low during a pending stall: pc=RESET_VECTOR, redirect_pending=0 asynchronously.
